ecc_encoder: RTL and testbench

Pipelined SECDED Hamming encoder that turns a data word into an 8-, 16- or 32-bit codeword for the selected width. It is the transmit-side counterpart of the syndrome/error-count logic. It also emits a parity vector already packed in the 6-bit format that error-count logic compares against. The block sits between the register interface and the channel/memory. It supports a valid/ready handshake on both sides, a throughput of one word per cycle and a latency of two cycles.

---
 rtl/ecc_encoder.sv | 197 +++++++++++++++++++
 tb/tb_ecc_encoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_encoder.sv
// ecc_encoder: two-stage pipelined SECDED Hamming encoder producing an
// 8/16/32-bit codeword plus a packed 6-bit parity vector.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   data_in, codeword_width  word to encode and its width select
//                            (00 small, 01 medium, 10/11 large)
//   in_valid / in_ready      upstream handshake
//   out_valid / out_ready    downstream handshake
//   codeword_out             zero-padded codeword
//   parity_out               packed parity for the error-count logic
//   width_out                width select carried with the word
//   word_count               saturating count of output handshakes
//
// Optional build macro ECC_ERR_INJECT_EN adds inj_en / inj_pos, which
// flip one codeword bit after encoding.

module ecc_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int AMBA_WORD  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            codeword_width,
`ifdef ECC_ERR_INJECT_EN
    input  logic                  inj_en,
    input  logic [4:0]            inj_pos,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AMBA_WORD-1:0]  codeword_out,
    output logic [5:0]            parity_out,
    output logic [1:0]            width_out,
    output logic [15:0]           word_count
);

    // Hamming position of data bit j: j-th integer >= 3 that is
    // not a power of two.
    function automatic logic [4:0] hpos(input int j);
        int n;
        logic [4:0] res;
        n   = 0;
        res = '0;
        for (int c = 3; c < 32; c++) begin
            if ((c & (c - 1)) != 0) begin
                if (n == j) res = 5'(c);
                n++;
            end
        end
        return res;
    endfunction

    logic        v1_q, v2_q;
    logic [25:0] d1_q, d1_d;
    logic [1:0]  w1_q, w2_q;
    logic [31:0] cw_q, cw_d, cw_clean;
    logic [5:0]  par_q, par_d;
    logic [15:0] cnt_q;
    logic [4:0]  chk;
    logic [4:0]  pos;
    logic        advance;
    logic        unused_hi;

`ifdef ECC_ERR_INJECT_EN
    logic        ie1_q;
    logic [4:0]  ip1_q;
`endif

    if (DATA_WIDTH > 26) begin : g_hi
        assign unused_hi = ^data_in[DATA_WIDTH-1:26];
    end else begin : g_nohi
        assign unused_hi = 1'b0;
    end

    assign advance  = !v2_q || out_ready;
    assign in_ready = !v1_q || advance;

    // Bits above K are zeroed so the encoder can treat every width
    // as a 26-bit word.
    always_comb begin
        d1_d = '0;
        case (codeword_width)
            2'b00:   d1_d[3:0]  = data_in[3:0];
            2'b01:   d1_d[10:0] = data_in[10:0];
            default: d1_d       = data_in[25:0];
        endcase
    end

    // Masked-off data bits are zero, so the five raw check bits are
    // valid for every width; only the overall bit depends on r.
    always_comb begin
        chk = '0;
        pos = '0;
        for (int j = 0; j < 26; j++) begin
            pos = hpos(j);
            for (int i = 0; i < 5; i++) begin
                if (pos[i]) chk[i] = chk[i] ^ d1_q[j];
            end
        end
    end

    always_comb begin
        cw_clean = '0;
        case (w1_q)
            2'b00: begin
                cw_clean[7:0] = {^d1_q ^ ^chk[2:0], chk[2:0], d1_q[3:0]};
            end
            2'b01: begin
                cw_clean[15:0] = {^d1_q ^ ^chk[3:0], chk[3:0], d1_q[10:0]};
            end
            default: begin
                cw_clean = {^d1_q ^ ^chk, chk, d1_q};
            end
        endcase
    end

`ifdef ECC_ERR_INJECT_EN
    always_comb begin
        cw_d = cw_clean;
        if (ie1_q) begin
            case (w1_q)
                2'b00:   if (ip1_q < 5'd8)  cw_d[ip1_q] = ~cw_clean[ip1_q];
                2'b01:   if (ip1_q < 5'd16) cw_d[ip1_q] = ~cw_clean[ip1_q];
                default: cw_d[ip1_q] = ~cw_clean[ip1_q];
            endcase
        end
    end
`else
    assign cw_d = cw_clean;
`endif

    // Parity is read back from the (possibly corrupted) codeword.
    always_comb begin
        par_d = '0;
        case (w1_q)
            2'b00:   par_d = {cw_d[7], 2'b00, cw_d[6:4]};
            2'b01:   par_d = {cw_d[15], 1'b0, cw_d[14:11]};
            default: par_d = cw_d[31:26];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            w1_q <= '0;
`ifdef ECC_ERR_INJECT_EN
            ie1_q <= 1'b0;
            ip1_q <= '0;
`endif
        end else if (in_ready) begin
            v1_q <= in_valid;
            if (in_valid) begin
                d1_q <= d1_d;
                w1_q <= codeword_width;
`ifdef ECC_ERR_INJECT_EN
                ie1_q <= inj_en;
                ip1_q <= inj_pos;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q  <= 1'b0;
            cw_q  <= '0;
            par_q <= '0;
            w2_q  <= '0;
        end else if (advance) begin
            v2_q <= v1_q;
            if (v1_q) begin
                cw_q  <= cw_d;
                par_q <= par_d;
                w2_q  <= w1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (v2_q && out_ready && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign out_valid    = v2_q;
    assign codeword_out = AMBA_WORD'(cw_q);
    assign parity_out   = par_q;
    assign width_out    = w2_q;
    assign word_count   = cnt_q;

endmodule

// File: tb/tb_ecc_encoder.sv
// tb_ecc_encoder: randomized and directed bench for ecc_encoder with a
// position-array Hamming model and an in-order scoreboard.

module tb_ecc_encoder;

`ifdef ECC_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] cw;
        logic [5:0]  par;
    } enc_t;

    typedef struct {
        logic [31:0] cw;
        logic [5:0]  par;
        logic [1:0]  w;
        int          idx;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = '0;
    logic [1:0]  codeword_width = '0;
    logic        inj_en = 1'b0;
    logic [4:0]  inj_pos = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] codeword_out;
    logic [5:0]  parity_out;
    logic [1:0]  width_out;
    logic [15:0] word_count;

    int pass_cnt = 0;
    int total = 0;

    sb_t q[$];
    int  nidx = 0;
    int  mcount = 0;

    ecc_encoder #(.DATA_WIDTH(32), .AMBA_WORD(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .codeword_width (codeword_width),
`ifdef ECC_ERR_INJECT_EN
        .inj_en         (inj_en),
        .inj_pos        (inj_pos),
`endif
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .codeword_out   (codeword_out),
        .parity_out     (parity_out),
        .width_out      (width_out),
        .word_count     (word_count)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, logic [63:0] act,
                                  logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endfunction

    // Lay data bits onto Hamming positions 1..2^r-1, then derive each
    // check bit from the positions whose index has that bit set.
    function automatic enc_t model(logic [31:0] data, logic [1:0] w,
                                   logic ie, logic [4:0] ip);
        int k, r, n, j;
        logic [31:0] d, cw, f;
        logic [5:0] p, par;
        bit cb[32];
        enc_t e;
        case (w)
            2'd0:    begin k = 4;  r = 3; n = 8;  end
            2'd1:    begin k = 11; r = 4; n = 16; end
            default: begin k = 26; r = 5; n = 32; end
        endcase
        d = data & ((32'd1 << k) - 32'd1);
        for (int i = 0; i < 32; i++) cb[i] = 1'b0;
        j = 0;
        for (int pq = 1; pq < (1 << r); pq++) begin
            if ((pq & (pq - 1)) != 0) begin
                cb[pq] = d[j];
                j++;
            end
        end
        p = '0;
        for (int i = 0; i < r; i++)
            for (int pq = 1; pq < (1 << r); pq++)
                if (((pq >> i) & 1) == 1) p[i] = p[i] ^ cb[pq];
        p[r] = ^d ^ ^p;
        cw = d | (32'(p) << k);
        if (INJ && ie && int'(ip) < n) cw[ip] = ~cw[ip];
        f = cw >> k;
        case (w)
            2'd0:    par = {f[3], 2'b00, f[2:0]};
            2'd1:    par = {f[4], 1'b0, f[3:0]};
            default: par = f[5:0];
        endcase
        e.cw = cw;
        e.par = par;
        return e;
    endfunction

    // Scoreboard: an accepted word must be presented two sampling
    // points later unless an older word is still waiting downstream.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mcount = 0;
        end else begin
            enc_t e;
            sb_t s;
            bit exp_ov;
            nidx++;
            exp_ov = (q.size() > 0) && (nidx - q[0].idx >= 2);
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            if (out_valid && q.size() > 0) begin
                check("sb_cw", 64'(codeword_out), 64'(q[0].cw));
                check("sb_par", 64'(parity_out), 64'(q[0].par));
                check("sb_w", 64'(width_out), 64'(q[0].w));
            end
            check("in_ready", 64'(in_ready),
                  64'((q.size() < 2) || out_ready));
            check("word_count", 64'(word_count), 64'(mcount));
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                if (mcount != 65535) mcount++;
            end
            if (in_valid && in_ready) begin
                e = model(data_in, codeword_width, inj_en, inj_pos);
                s.cw = e.cw;
                s.par = e.par;
                s.w = codeword_width;
                s.idx = nidx;
                q.push_back(s);
            end
        end
    end

    task automatic send_one(logic [31:0] dt, logic [1:0] w, logic ie,
                            logic [4:0] ip, logic [31:0] ecw,
                            logic [5:0] epar);
        int n;
        bit seen;
        @(posedge clk); #1;
        data_in = dt;
        codeword_width = w;
        inj_en = ie;
        inj_pos = ip;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        inj_en = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
        end
        check("dir_latency", 64'(n), 64'd2);
        check("dir_cw", 64'(codeword_out), 64'(ecw));
        check("dir_par", 64'(parity_out), 64'(epar));
        check("dir_w", 64'(width_out), 64'(w));
    endtask

    initial begin
        enc_t e;
        int acc, n;
        logic [31:0] held;

        // Model pinned to hand-computed encodings.
        e = model(32'h0000000B, 2'd0, 1'b0, 5'd0);
        check("model_small_cw", 64'(e.cw), 64'h1B);
        check("model_small_par", 64'(e.par), 64'h01);
        e = model(32'h000007FF, 2'd1, 1'b0, 5'd0);
        check("model_med_cw", 64'(e.cw), 64'hFFFF);
        check("model_med_par", 64'(e.par), 64'h2F);
        e = model(32'h03FFFFFF, 2'd2, 1'b0, 5'd0);
        check("model_large_cw", 64'(e.cw), 64'hFFFFFFFF);
        check("model_large_par", 64'(e.par), 64'h3F);

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_cw", 64'(codeword_out), 64'd0);
        check("rst_par", 64'(parity_out), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        send_one(32'h0000000B, 2'b00, 1'b0, 5'd0, 32'h1B, 6'h01);
        send_one(32'h000007FF, 2'b01, 1'b0, 5'd0, 32'hFFFF, 6'h2F);
        send_one(32'h03FFFFFF, 2'b10, 1'b0, 5'd0, 32'hFFFFFFFF, 6'h3F);
        send_one(32'h03FFFFFF, 2'b11, 1'b0, 5'd0, 32'hFFFFFFFF, 6'h3F);
        send_one(32'hFFFFFFF0, 2'b00, 1'b0, 5'd0, 32'h0, 6'h00);
`ifdef ECC_ERR_INJECT_EN
        send_one(32'h0000000B, 2'b00, 1'b1, 5'd2, 32'h1F, 6'h01);
        send_one(32'h0000000B, 2'b00, 1'b1, 5'd9, 32'h1B, 6'h01);
`endif

        // Backpressure: fresh count, four words against a stalled sink.
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        codeword_width = 2'b01;
        data_in = 32'h00000123;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            data_in = 32'h00000123 + 32'(acc);
        end
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        held = codeword_out;
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold", 64'(codeword_out), 64'(held));
        out_ready = 1'b1;
        n = 0;
        while (acc < 4 && n < 20) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            data_in = 32'h00000123 + 32'(acc);
            if (acc >= 4) in_valid = 1'b0;
            n++;
        end
        n = 0;
        while (word_count != 16'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_word_count", 64'(word_count), 64'd4);

        // Reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        check("mid_full", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_count", 64'(word_count), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        check("mid_cw", 64'(codeword_out), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            in_valid = ($urandom % 4) != 0;
            out_ready = (c % 200 < 20) ? 1'b0 : (($urandom % 4) != 0);
            codeword_width = 2'($urandom % 4);
            data_in = $urandom;
            inj_en = 1'($urandom % 2);
            inj_pos = 5'($urandom % 32);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
